// File: rtl/vectored_int_ctrl.sv
// vectored_int_ctrl: n_src-channel fixed-priority vectored interrupt controller with nesting
module vectored_int_ctrl #(
  parameter int n_src = 8,
  parameter int id_width = 3,
  parameter int v_width = 8,
  parameter logic [v_width-1:0] vec_base = 8'hF0,
  parameter int unsigned vec_step = 1
) (
  input  logic                g_clk,
  input  logic                g_clr,
  input  logic [n_src-1:0]    int_src,
  input  logic [n_src-1:0]    edge_mode,
  input  logic [n_src-1:0]    mask,
  input  logic                ien,
  input  logic                int_ack,
  input  logic                int_ret,
  input  logic [n_src-1:0]    sw_clr,
  output logic                i_pending,
  output logic [v_width-1:0]  vector,
  output logic [id_width-1:0] active_id,
  output logic [n_src-1:0]    in_service
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_d;
  logic [n_src-1:0] src_q, pending, pending_d, isr_ret, isr_d, below, elig, ack_clr;
  logic [id_width-1:0] win, id_d;
  logic [v_width-1:0] vec_d;
  logic ip_d, ack_fire, any;
  assign ack_fire = (state == REQ) & int_ack;
  assign ack_clr = ack_fire ? n_src'(1) << active_id : '0;
  // edge set wins over sw_clr/ack clear; level channels simply follow the line
  assign pending_d = (edge_mode & ((pending & ~(sw_clr | ack_clr)) | (int_src & ~src_q))) | (~edge_mode & int_src);
  assign isr_ret = int_ret ? in_service & (in_service - n_src'(1)) : in_service;
  assign isr_d = isr_ret | ack_clr;
  // only channels strictly below the lowest in-service index may nest
  assign below = |in_service ? (in_service & (~in_service + n_src'(1))) - n_src'(1) : '1;
  assign elig = pending & mask & below & {n_src{ien}};
  assign any = |elig;
  always_comb begin
    win = '0;
    for (int i = n_src - 1; i >= 0; i--)
      if (elig[i]) win = id_width'(i);
  end
  always_comb begin
    state_d = state;
    id_d = active_id;
    vec_d = vector;
    ip_d = i_pending;
    if (state == IDLE) begin
      if (any) begin
        state_d = REQ;
        id_d = win;
        vec_d = vec_base + v_width'(32'(win) * vec_step);
        ip_d = 1'b1;
      end
    end else if (int_ack | ~elig[active_id]) begin
      state_d = IDLE;
      ip_d = 1'b0;
    end
  end
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      state <= IDLE;
      src_q <= '0;
      pending <= '0;
      in_service <= '0;
      active_id <= '0;
      vector <= vec_base;
      i_pending <= 1'b0;
    end else begin
      state <= state_d;
      src_q <= int_src;
      pending <= pending_d;
      in_service <= isr_d;
      active_id <= id_d;
      vector <= vec_d;
      i_pending <= ip_d;
    end
  end
endmodule

// File: tb/tb_vectored_int_ctrl.sv
// tb_vectored_int_ctrl: directed stimulus with a cycle-level reference model and literal checks
module tb_vectored_int_ctrl;
  logic g_clk = 1'b0, g_clr = 1'b1;
  logic [7:0] int_src = '0, edge_mode = 8'hFF, mask = 8'hFF, sw_clr = '0;
  logic ien = 1'b1, int_ack = 1'b0, int_ret = 1'b0;
  logic i_pending;
  logic [7:0] vector, in_service;
  logic [2:0] active_id;
  logic [3:0] src2 = '0;
  logic ip2;
  logic [7:0] vec2;
  logic [1:0] id2;
  logic [3:0] isr2;
  int n_checks = 0, n_fail = 0;

  vectored_int_ctrl dut (.g_clk(g_clk), .g_clr(g_clr), .int_src(int_src), .edge_mode(edge_mode),
    .mask(mask), .ien(ien), .int_ack(int_ack), .int_ret(int_ret), .sw_clr(sw_clr),
    .i_pending(i_pending), .vector(vector), .active_id(active_id), .in_service(in_service));

  vectored_int_ctrl #(.n_src(4), .id_width(2), .v_width(8), .vec_base(8'hFE), .vec_step(2)) dut2 (
    .g_clk(g_clk), .g_clr(g_clr), .int_src(src2), .edge_mode(4'hF), .mask(4'hF), .ien(1'b1),
    .int_ack(1'b0), .int_ret(1'b0), .sw_clr(4'h0), .i_pending(ip2), .vector(vec2),
    .active_id(id2), .in_service(isr2));

  always #5 g_clk = ~g_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: per-channel bits and the currently presented channel
  bit m_pend[8], m_isr[8], m_src[8], m_elig[8], m_new_pend[8];
  bit m_pres, m_ack;
  int m_id, m_win, m_top;

  always @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 0; m_isr[i] = 0; m_src[i] = 0;
      end
      m_pres = 0; m_id = 0;
    end else begin
      m_top = 8;
      for (int i = 7; i >= 0; i--) if (m_isr[i]) m_top = i;
      m_win = -1;
      for (int i = 0; i < 8; i++) begin
        m_elig[i] = m_pend[i] && mask[i] && ien && (i < m_top);
        if (m_elig[i] && m_win < 0) m_win = i;
      end
      m_ack = m_pres && int_ack;
      for (int i = 0; i < 8; i++)
        m_new_pend[i] = edge_mode[i]
          ? ((m_pend[i] && !sw_clr[i] && !(m_ack && m_id == i)) || (int_src[i] && !m_src[i]))
          : int_src[i];
      if (int_ret && m_top < 8) m_isr[m_top] = 0;
      if (m_ack) m_isr[m_id] = 1;
      if (!m_pres) begin
        if (m_win >= 0) begin m_pres = 1; m_id = m_win; end
      end else if (m_ack || !m_elig[m_id]) m_pres = 0;
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = m_new_pend[i]; m_src[i] = int_src[i];
      end
    end
  end

  function automatic logic [7:0] m_isr_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_isr[i];
    return v;
  endfunction

  always @(negedge g_clk) begin
    if (!g_clr) begin
      chk("model_i_pending", i_pending, m_pres);
      chk("model_in_service", in_service, m_isr_vec());
      chk("model_active_id", active_id, m_id);
      chk("model_vector", vector, (240 + m_id) % 256);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge g_clk);
  endtask
  task automatic pulse_src(input int i);
    int_src[i] = 1'b1; step(); int_src[i] = 1'b0;
  endtask
  task automatic do_ack();
    int_ack = 1'b1; step(); int_ack = 1'b0;
  endtask
  task automatic do_ret();
    int_ret = 1'b1; step(); int_ret = 1'b0;
  endtask

  initial begin
    step(2);
    g_clr = 1'b0;
    step();
    chk("rst_vector", vector, 8'hF0);
    chk("rst_isr", in_service, 8'h00);
    chk("rst_ip", i_pending, 1'b0);
    // single edge request on channel 3
    pulse_src(3); step();
    chk("edge3_ip", i_pending, 1'b1);
    chk("edge3_vec", vector, 8'hF3);
    chk("edge3_id", active_id, 3'd3);
    do_ack();
    chk("edge3_ack_ip", i_pending, 1'b0);
    chk("edge3_ack_isr", in_service, 8'h08);
    step(2);
    chk("edge3_cleared", i_pending, 1'b0);
    do_ret();
    chk("edge3_ret_isr", in_service, 8'h00);
    // nesting: 5 in service, then 6 and 2 together
    pulse_src(5); step(); do_ack();
    chk("nest_isr5", in_service, 8'h20);
    int_src[6] = 1'b1; int_src[2] = 1'b1; step(); int_src[6] = 1'b0; int_src[2] = 1'b0; step();
    chk("nest_vec2", vector, 8'hF2);
    chk("nest_ip2", i_pending, 1'b1);
    do_ack();
    chk("nest_isr24", in_service, 8'h24);
    step(2);
    chk("nest_blocked", i_pending, 1'b0);
    do_ret();
    chk("nest_ret1", in_service, 8'h20);
    step(2);
    chk("nest_still_blocked", i_pending, 1'b0);
    do_ret();
    chk("nest_ret2", in_service, 8'h00);
    step();
    chk("nest_vec6", vector, 8'hF6);
    chk("nest_ip6", i_pending, 1'b1);
    do_ack(); do_ret();
    // level withdraw
    edge_mode[1] = 1'b0; int_src[1] = 1'b1; step(2);
    chk("lvl_vec", vector, 8'hF1);
    chk("lvl_ip", i_pending, 1'b1);
    int_src[1] = 1'b0; step(2);
    chk("lvl_withdraw", i_pending, 1'b0);
    chk("lvl_isr", in_service, 8'h00);
    edge_mode[1] = 1'b1;
    // ack and ret in the same cycle
    pulse_src(5); step(); do_ack();
    pulse_src(4); step();
    chk("sim_vec4", vector, 8'hF4);
    int_ack = 1'b1; int_ret = 1'b1; step(); int_ack = 1'b0; int_ret = 1'b0;
    chk("sim_isr", in_service, 8'h10);
    do_ret();
    // sw_clr colliding with an edge: the set wins
    int_src[7] = 1'b1; sw_clr[7] = 1'b1; step(); int_src[7] = 1'b0; sw_clr[7] = 1'b0; step();
    chk("swclr_edge_ip", i_pending, 1'b1);
    chk("swclr_edge_vec", vector, 8'hF7);
    do_ack(); do_ret();
    // sw_clr alone removes a masked pending edge
    mask[6] = 1'b0; pulse_src(6); step();
    sw_clr[6] = 1'b1; step(); sw_clr[6] = 1'b0; mask[6] = 1'b1; step(2);
    chk("swclr_removed", i_pending, 1'b0);
    do_ack();
    chk("ack_idle_ignored", in_service, 8'h00);
    // second instance: wrap-around vector
    src2[2] = 1'b1; step(); src2[2] = 1'b0; step();
    chk("wrap_vec", vec2, 8'h02);
    chk("wrap_id", id2, 2'd2);
    chk("wrap_ip", ip2, 1'b1);
    // async reset mid-REQ with a channel in service
    pulse_src(3); step(); do_ack();
    pulse_src(1); step();
    chk("pre_rst_vec", vector, 8'hF1);
    #3 g_clr = 1'b1;
    #1 chk("async_rst_ip", i_pending, 1'b0);
    step(); g_clr = 1'b0; step();
    chk("post_rst_vec", vector, 8'hF0);
    chk("post_rst_isr", in_service, 8'h00);
    chk("post_rst_id", active_id, 3'd0);
    chk("post_rst_ip", i_pending, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
